// File: rtl/demo_uart_rx.sv
// demo_uart_rx: 8N1 UART receiver with a single-entry holding register
// on a valid/ready byte interface.

module demo_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("demo_uart_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    // Two-flop synchronizer; line_s is the only view of the serial line.
    logic [1:0]    sync_q, sync_d;
    logic          line_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;

    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic          byte_done;

    assign sync_d = {sync_q[0], uart_rx_i};
    assign line_s = sync_q[1];

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!line_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (line_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {line_s, shift_q[7:1]};
                    cnt_d   = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (line_s) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_WAIT_IDLE: begin
                // A break or misframed stream must go high before re-arming.
                if (line_s) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // A completed byte replaces the held one only if the slot is free or
    // being drained this very cycle; otherwise the new byte is dropped.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;

        if (byte_done) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' only; every flop here,
    // including the data holding register, gets an explicit reset value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_valid_o  = valid_q;
    assign rx_data_o   = data_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/demo_uart_rx.md
# demo_uart_rx

UART receiver for the demo SoC's serial line. It deserializes the 8N1 stream driven on the SoC's `uart_tx_o` into bytes and presents them on a valid/ready byte interface. The block is the receiving end of the demo UART link. It serves two roles:
- a synthesizable host-side/loopback peer;
- a self-checking monitor in the demo testbench, replacing the constant-idle line tie-off.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (e.g. 50 MHz / 115200 baud); must be ≥ 4.

Ports:
- `clk_i`  in  1  sole clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `uart_rx_i`  in  1  serial line, idle high, asynchronous to `clk_i`.
- `rx_valid_o`  out  1  holding register contains an unread byte.
- `rx_ready_i`  in  1  consumer accepts the byte; transfer when valid & ready.
- `rx_data_o`  out  8  received byte; stable while `rx_valid_o` high.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: byte completed while holding register full and not drained.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `uart_rx_i` passes through 2 flops. Both reset to 1. The result is `line_s`. No other logic uses `uart_rx_i` directly.
- **Bit counter:**
  - width `$clog2(CLKS_PER_BIT)`;
  - bit index 0..7;
  - 8-bit shift register, LSB first (new bit enters at MSB, shifts right).
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: if `line_s`==0, go to START with counter=0.
  - START: count to `CLKS_PER_BIT/2 - 1` (integer division), then sample.
    - `line_s`==1 → false start, back to IDLE, nothing reported.
    - else → DATA with counter=0, index=0.
  - DATA: count to `CLKS_PER_BIT-1`, then sample `line_s` into the shift register and reset the counter.
    - After index 7 is sampled → STOP.
  - STOP: count to `CLKS_PER_BIT-1`, then sample.
    - 1 → byte complete, go to IDLE.
    - 0 → pulse `frame_err_o`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `line_s`==1, then IDLE. This prevents a break or misframed stream from re-triggering mid-low.
- **Holding register:**
  - On byte complete with `rx_valid_o`==0, or with `rx_valid_o`==1 and `rx_ready_i`==1 in the same cycle: load the byte and set valid. No overrun.
  - On byte complete with `rx_valid_o`==1 and `rx_ready_i`==0: keep the old byte, drop the new one, pulse `overrun_o`.
  - Handshake without a new byte: clear valid the next cycle; `rx_data_o` keeps its last value.
- A framing error never touches the holding register.
- The receiver keeps receiving regardless of consumer backpressure.

## Timing
- **Reset values:**
  - `rx_valid_o`=0, `rx_data_o`=0x00, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0;
  - FSM=IDLE, counters=0, synchronizer flops=1.
- **Definitions:** T = first cycle with `line_s`==0 in IDLE; H = `CLKS_PER_BIT/2`.
- **Input latency:** 2 cycles from `uart_rx_i` to `line_s`.
- **Sample points:**
  - Start-bit sample at T+H.
  - Data bit k (k=0..7) at T+H+(k+1)·`CLKS_PER_BIT`.
  - Stop sample at T+H+9·`CLKS_PER_BIT`.
- **Output timing:**
  - `rx_valid_o` rises, or `frame_err_o`/`overrun_o` pulse, on the cycle after the stop sample.
  - `busy_o` falls on that same cycle, or later if the FSM goes through WAIT_IDLE.
- **Back-to-back frames:** a start edge arriving the cycle IDLE is re-entered is detected with no lost cycle.
- **Reset mid-frame:**
  - All state is cleared immediately (asynchronously).
  - After deassertion the block waits for a falling edge in IDLE.
  - Remaining low bits of an interrupted frame may be taken as a start bit. Those frames are not guaranteed; a garbage byte or frame error is permitted.
- **Backpressure:** `rx_ready_i` may be held high permanently; each byte is then valid for exactly 1 cycle.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and ideal bit timing unless stated.
- **Single byte:** send 0xA5 with `rx_ready_i`=1. Expect:
  - `rx_valid_o` high for 1 cycle with `rx_data_o`=0xA5;
  - `busy_o` high from T to the stop sample;
  - no error pulses.
- **Back-to-back with drift:** send 0x00, 0xFF, 0x5A with zero idle gap, plus a ±1-cycle edge jitter variant. Expect three valid beats in order with exactly those values.
- **Glitch rejection:** drive a low of 4 cycles, then idle. Expect:
  - `busy_o` returns low within H+3 cycles;
  - no `rx_valid_o`, no `frame_err_o`.
- **Framing error and recovery:** send 0x55 with stop bit 0, hold the line low 40 cycles, then idle, then send 0x3C. Expect:
  - a single `frame_err_o` pulse;
  - no valid for 0x55;
  - 0x3C received correctly.
- **Overrun:** `rx_ready_i`=0, send 0x11 then 0x22. Expect:
  - `overrun_o` pulses once at the end of 0x22;
  - `rx_data_o` stays 0x11.
  - Then raise `rx_ready_i`: one transfer of 0x11, then valid drops.
- **Simultaneous accept and complete, plus reset:**
  - With 0x11 held, assert `rx_ready_i` exactly on the completion cycle of 0x22. Expect 0x22 loaded, valid stays high, no overrun.
  - Then assert `rst_i` mid-frame. Expect all outputs at reset values immediately; the next clean frame 0x7E after line idle is received.
